// File: rtl/fp_arb_pkg.sv
// Shared definitions for the fp_add_arbiter slice: FSM encoding, the default
// operand width and the round-robin pick function used by rr_arbiter.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FP_XLEN  = 32;
  // Widest requester count the pick function has to cover.
  localparam int MAX_NREQ = 16;

  // One-hot grant for the first set valid bit, searching upward from ptr+1
  // and wrapping modulo nreq. Returns zero when nothing is valid.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [3:0]          ptr,
    input int                  nreq
  );
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    logic [3:0]          idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= nreq) begin
        idx = 4'((int'(ptr) + k) % nreq);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from the last winner plus
// one, and a pointer that only moves when the caller signals a handshake.
module rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_update,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id
);

  logic [IDW-1:0]      r_ptr;
  logic [MAX_NREQ-1:0] w_valid_pad;
  logic [MAX_NREQ-1:0] w_grant_pad;

  // Widen to the pick function's fixed width, pick, and encode the winner.
  always_comb begin
    w_valid_pad             = '0;
    w_valid_pad[NREQ-1:0]   = i_valid;
    w_grant_pad             = rr_pick(w_valid_pad, 4'(r_ptr), NREQ);
    o_grant                 = w_grant_pad[NREQ-1:0];
    o_grant_id              = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (w_grant_pad[i]) begin
        o_grant_id = IDW'(i);
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (i_update) begin
      r_ptr <= o_grant_id;
    end
  end

endmodule

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder (ports a/b/result).
// Aligns, adds/subtracts and normalises; the fraction is truncated rather than
// rounded. NaN inputs or inf-inf give the quiet NaN 0x7FC00000, infinities
// pass through, subnormals are handled with an effective exponent of 1.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic        w_swap;
  logic        w_big_s, w_sml_s;
  logic [7:0]  w_ea_eff, w_eb_eff;
  logic [7:0]  w_big_e, w_sml_e, w_diff;
  logic [23:0] w_ma, w_mb, w_big_m, w_sml_m;
  logic [27:0] w_sml_ext, w_sum;
  logic [9:0]  w_exp;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  // Align the smaller magnitude to the larger, combine, normalise and pack.
  always_comb begin
    w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_ea_eff = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    w_eb_eff = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    w_ma     = {|a[30:23], a[22:0]};
    w_mb     = {|b[30:23], b[22:0]};
    w_swap   = {w_eb_eff, w_mb} > {w_ea_eff, w_ma};
    w_big_s  = w_swap ? b[31]    : a[31];
    w_sml_s  = w_swap ? a[31]    : b[31];
    w_big_e  = w_swap ? w_eb_eff : w_ea_eff;
    w_sml_e  = w_swap ? w_ea_eff : w_eb_eff;
    w_big_m  = w_swap ? w_mb     : w_ma;
    w_sml_m  = w_swap ? w_ma     : w_mb;
    w_diff   = w_big_e - w_sml_e;
    // Three extra low bits keep a little precision through the alignment.
    w_sml_ext = {1'b0, w_sml_m, 3'b000} >> w_diff;
    if (w_big_s == w_sml_s) begin
      w_sum = {1'b0, w_big_m, 3'b000} + w_sml_ext;
    end else begin
      w_sum = {1'b0, w_big_m, 3'b000} - w_sml_ext;
    end
    w_exp = {2'b00, w_big_e};
    if (w_sum[27]) begin
      w_sum = w_sum >> 1;
      w_exp = w_exp + 10'd1;
    end else begin
      // Shift left until the hidden bit is set, stopping at the subnormal floor.
      for (int i = 0; i < 26; i++) begin
        if (!w_sum[26] && (w_exp > 10'd1)) begin
          w_sum = w_sum << 1;
          w_exp = w_exp - 10'd1;
        end
      end
    end
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31]))) begin
      result = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      result = a;
    end else if (w_b_inf) begin
      result = b;
    end else if (w_sum == 28'd0) begin
      result = {a[31] & b[31], 31'd0};
    end else if (w_exp >= 10'd255) begin
      result = {w_big_s, 8'hFF, 23'd0};
    end else begin
      result = {w_big_s, (w_sum[26] ? w_exp[7:0] : 8'd0), w_sum[25:3]};
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational fp_adder between NREQ requesters
// with round-robin arbitration and valid/ready request/response handshakes.
// Optional macro FP_ARB_SUB_EN adds req_sub: a granted requester with its bit
// set gets A-B (sign of B flipped ahead of the adder) instead of A+B.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int XLEN = FP_XLEN,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
`ifdef FP_ARB_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 busy
);

  state_t          r_state, w_state_next;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_id;
  logic            w_hs;
  logic [XLEN-1:0] w_a_slices [NREQ];
  logic [XLEN-1:0] w_b_slices [NREQ];
  logic [XLEN-1:0] r_op_a, r_op_b, w_add_b, w_sum;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;

  // Unpack the flat operand buses into per-requester words.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_a_slices[gi] = req_a[gi*XLEN +: XLEN];
    assign w_b_slices[gi] = req_b[gi*XLEN +: XLEN];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (req_valid),
    .i_update   (w_hs),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  // A grant exists only while some req_valid is set, so it is the handshake.
  assign w_hs = (r_state == IDLE) && (|w_grant);

`ifdef FP_ARB_SUB_EN
  logic r_sub;
  assign w_add_b = {r_op_b[XLEN-1] ^ r_sub, r_op_b[XLEN-2:0]};
`else
  assign w_add_b = r_op_b;
`endif

  fp_adder u_add (
    .a      (r_op_a),
    .b      (w_add_b),
    .result (w_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grant visibility and busy.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_hs) begin
          w_state_next = CALC;
        end
      end
      CALC: begin
        busy         = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture on grant, result capture in CALC, response handshake in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
`ifdef FP_ARB_SUB_EN
      r_sub        <= 1'b0;
`endif
    end else begin
      if (w_hs) begin
        r_op_a <= w_a_slices[w_grant_id];
        r_op_b <= w_b_slices[w_grant_id];
        r_id   <= w_grant_id;
`ifdef FP_ARB_SUB_EN
        r_sub  <= req_sub[w_grant_id];
`endif
      end
      if (r_state == CALC) begin
        r_rsp_result <= w_sum;
        r_rsp_id     <= r_id;
        r_rsp_valid  <= 1'b1;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a table of single-request sums, then
// round-robin order, backpressure, pointer fairness and reset mid-operation.
module tb_fp_add_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*XLEN-1:0] req_a = '0;
  logic [NREQ*XLEN-1:0] req_b = '0;
`ifdef FP_ARB_SUB_EN
  logic [NREQ-1:0]      req_sub = '0;
`endif
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_result;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs [10];

  fp_add_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef FP_ARB_SUB_EN
    .req_sub    (req_sub),
`endif
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full operation from requester id with rsp_ready high; starts and ends
  // on a falling edge with the DUT idle.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    req_valid                 = '0;
    req_valid[id]             = 1'b1;
    req_a[id*XLEN +: XLEN]    = a;
    req_b[id*XLEN +: XLEN]    = b;
    rsp_ready                 = 1'b1;
    #1;
    check({name, " grant"}, 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " calc_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({name, " valid"}, 32'(rsp_valid), 32'd1);
    check({name, " id"}, 32'(rsp_id), 32'(id));
    check({name, " result"}, rsp_result, exp);
    @(negedge clk);
    check({name, " done"}, 32'(rsp_valid), 32'd0);
    check({name, " held"}, rsp_result, exp);
    $display("op %s: req %0d a=%08h b=%08h -> %08h", name, id, a, b, rsp_result);
  endtask

  initial begin
    int          budget;
    int          highs;
    logic [31:0] rr_exp [4];

    vecs[0] = '{0, 32'h3FC00000, 32'h40200000, 32'h40800000}; // 1.5+2.5
    vecs[1] = '{1, 32'h3F800000, 32'h40000000, 32'h40400000}; // 1+2
    vecs[2] = '{2, 32'h40400000, 32'hBF800000, 32'h40000000}; // 3+(-1)
    vecs[3] = '{3, 32'h3F800000, 32'hBF800000, 32'h00000000}; // 1+(-1)
    vecs[4] = '{0, 32'h00000000, 32'h00000000, 32'h00000000}; // 0+0
    vecs[5] = '{1, 32'h40000000, 32'h3F000000, 32'h40200000}; // 2+0.5
    vecs[6] = '{2, 32'hC0000000, 32'hC0400000, 32'hC0A00000}; // -2+(-3)
    vecs[7] = '{3, 32'h3F000000, 32'h3E800000, 32'h3F400000}; // 0.5+0.25
    vecs[8] = '{0, 32'h7F800000, 32'h3F800000, 32'h7F800000}; // inf+1
    vecs[9] = '{1, 32'h41200000, 32'hC1280000, 32'hBF000000}; // 10+(-10.5)

    // Reset state.
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single-request sums.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));
    end

    // Fresh pointer, then all four requesting continuously: order 0,1,2,3,0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_exp[0] = 32'h40000000;
    rr_exp[1] = 32'h40400000;
    rr_exp[2] = 32'h40800000;
    rr_exp[3] = 32'h40A00000;
    req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b = {4{32'h3F800000}};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!rsp_valid && budget < 10);
      check($sformatf("rr%0d valid", n), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d id", n), 32'(rsp_id), 32'(n % 4));
      check($sformatf("rr%0d result", n), rsp_result, rr_exp[n % 4]);
      check($sformatf("rr%0d ready_low", n), 32'(req_ready), 32'd0);
      if (n > 0) check($sformatf("rr%0d spacing", n), 32'(budget), 32'd3);
      $display("rr response %0d: id=%0d result=%08h after %0d cycles", n, rsp_id, rsp_result, budget);
    end
    req_valid = '0;
    @(negedge clk);

    // Backpressure on requester 2's 1.0+2.0 while 1 and 3 wait.
    req_a[2*XLEN +: XLEN] = 32'h3F800000;
    req_b[2*XLEN +: XLEN] = 32'h40000000;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    check("bp grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b1010;
    check("bp calc ready_low", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d id", c), 32'(rsp_id), 32'd2);
      check($sformatf("bp%0d result", c), rsp_result, 32'h40400000);
      check($sformatf("bp%0d ready_low", c), 32'(req_ready), 32'd0);
    end
    $display("backpressure: held id=%0d result=%08h for 5 cycles", rsp_id, rsp_result);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid), 32'd0);
    check("bp release held", rsp_result, 32'h40400000);
    // Pointer is 2, so requester 3 wins over requester 1.
    check("fair grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    check("fair id3", 32'(rsp_id), 32'd3);
    check("fair result3", rsp_result, 32'h40A00000);
    @(negedge clk);
    check("fair grant1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("fair id1", 32'(rsp_id), 32'd1);
    check("fair result1", rsp_result, 32'h40400000);
    $display("fairness: 3 then 1 served");
    @(negedge clk);

    // Reset while in CALC: no response afterwards, pointer back to 3.
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) highs++;
    end
    check("rst no_response", 32'(highs), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("rst first grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    $display("reset in CALC: response suppressed, req 0 first");
    @(negedge clk);

`ifdef FP_ARB_SUB_EN
    req_sub = 4'b0010;
    run_op(1, 32'h40400000, 32'h3F800000, 32'h40000000, "sub");
    req_sub = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
